// File: rtl/onewire_master_ctrl.sv
// onewire_master_ctrl: byte-level 1-wire bus master.
// Generates reset/presence, write-slot and read-slot waveforms on an open-drain line.
// Optional feature macro: ONEWIRE_CRC8_EN adds a running Dallas CRC8 over read bits and the crc_ok port.
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | waiting for a command, cmd_ready=1
// RST_LOW  | reset pulse, bus held low
// RST_REL  | bus released, sample presence, then check for a short
// SLOT_LOW | low portion of a write or read slot
// SLOT_REL | released portion of the slot, read bits sampled here
// DONE     | one-cycle response strobe, result registers just loaded
module onewire_master_ctrl #(
  parameter int CLK_PER_US  = 1,
  parameter int RST_LOW_US  = 500,
  parameter int PRES_SMP_US = 70,
  parameter int RST_REC_US  = 500,
  parameter int W1_LOW_US   = 10,
  parameter int W0_LOW_US   = 90,
  parameter int RD_SMP_US   = 15,
  parameter int SLOT_US     = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       rsp_presence,
  output logic       rsp_short,
`ifdef ONEWIRE_CRC8_EN
  output logic       crc_ok,
`endif
  inout  wire        onewire_bus
);

  localparam int TW = $clog2(RST_REC_US * CLK_PER_US + 1);
  typedef logic [TW-1:0] tmr_t;

  // Timer counts from 0 on state entry, so an N-cycle state ends at N-1.
  localparam tmr_t RST_LOW_END = tmr_t'(RST_LOW_US * CLK_PER_US - 1);
  localparam tmr_t RST_REC_END = tmr_t'(RST_REC_US * CLK_PER_US - 1);
  localparam tmr_t PRES_PT     = tmr_t'(PRES_SMP_US * CLK_PER_US + 2);
  localparam tmr_t W1_LOW_END  = tmr_t'(W1_LOW_US * CLK_PER_US - 1);
  localparam tmr_t W0_LOW_END  = tmr_t'(W0_LOW_US * CLK_PER_US - 1);
  localparam tmr_t W1_REL_END  = tmr_t'((SLOT_US - W1_LOW_US) * CLK_PER_US - 1);
  localparam tmr_t W0_REL_END  = tmr_t'((SLOT_US - W0_LOW_US) * CLK_PER_US - 1);
  // Read sample point is slot-relative; the release-phase timer starts W1_LOW into the slot.
  localparam tmr_t RD_PT       = tmr_t'((RD_SMP_US - W1_LOW_US) * CLK_PER_US + 2);

  localparam logic [1:0] OP_RESET = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_BIT   = 2'b11;

  typedef enum logic [2:0] {
    IDLE, RST_LOW, RST_REL, SLOT_LOW, SLOT_REL, DONE
  } state_t;

  state_t     state, state_next;
  tmr_t       timer;
  logic [1:0] op_q;
  logic [7:0] data_q;
  logic [2:0] bit_cnt;
  logic [7:0] rd_sr;
  logic       pres_q;
  logic       bus_s1, bus_s2;
  logic       slot_one;
  logic       drive_low;
  logic       rd_sample;
  tmr_t       low_end;
  tmr_t       rel_end;

  // Read slots and write-1 slots share the short low time.
  assign slot_one  = (op_q == OP_READ) || data_q[bit_cnt];
  assign low_end   = slot_one ? W1_LOW_END : W0_LOW_END;
  assign rel_end   = slot_one ? W1_REL_END : W0_REL_END;
  assign rd_sample = (state == SLOT_REL) && (op_q == OP_READ) && (timer == RD_PT);

  assign drive_low   = (state == RST_LOW) || (state == SLOT_LOW);
  assign onewire_bus = drive_low ? 1'b0 : 1'bz;
  assign cmd_ready   = (state == IDLE);
  assign rsp_valid   = (state == DONE);

  // Two-flop synchronizer on the shared line.
  always_ff @(posedge clk) begin
    if (!reset) begin
      bus_s1 <= 1'b1;
      bus_s2 <= 1'b1;
    end else begin
      bus_s1 <= onewire_bus;
      bus_s2 <= bus_s1;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (cmd_valid) state_next = (cmd_op == OP_RESET) ? RST_LOW : SLOT_LOW;
      RST_LOW:  if (timer == RST_LOW_END) state_next = RST_REL;
      RST_REL:  if (timer == RST_REC_END) state_next = DONE;
      SLOT_LOW: if (timer == low_end) state_next = SLOT_REL;
      SLOT_REL: begin
        if (timer == rel_end)
          state_next = ((bit_cnt == 3'd7) || (op_q == OP_BIT)) ? DONE : SLOT_LOW;
      end
      DONE:     state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // Phase timer: restarts on every state change, parked at zero when not timing.
  always_ff @(posedge clk) begin
    if (!reset)
      timer <= '0;
    else if ((state_next != state) || (state == IDLE) || (state == DONE))
      timer <= '0;
    else
      timer <= timer + tmr_t'(1);
  end

  // Command capture, bit sequencing and sample capture.
  always_ff @(posedge clk) begin
    if (!reset) begin
      op_q    <= OP_RESET;
      data_q  <= '0;
      bit_cnt <= '0;
      rd_sr   <= '0;
      pres_q  <= 1'b0;
    end else begin
      if ((state == IDLE) && cmd_valid) begin
        op_q    <= cmd_op;
        data_q  <= cmd_data;
        bit_cnt <= '0;
        rd_sr   <= '0;
        pres_q  <= 1'b0;
      end
      if ((state == RST_REL) && (timer == PRES_PT))
        pres_q <= ~bus_s2;
      if (rd_sample)
        rd_sr <= {bus_s2, rd_sr[7:1]};
      if ((state == SLOT_REL) && (state_next == SLOT_LOW))
        bit_cnt <= bit_cnt + 3'd1;
    end
  end

  // Result registers load on the edge entering DONE and hold until the next one.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rsp_data     <= '0;
      rsp_presence <= 1'b0;
      rsp_short    <= 1'b0;
    end else if ((state_next == DONE) && (state != DONE)) begin
      rsp_data     <= (op_q == OP_READ) ? rd_sr : 8'h00;
      rsp_presence <= (op_q == OP_RESET) ? pres_q : 1'b0;
      rsp_short    <= (op_q == OP_RESET) ? ~bus_s2 : 1'b0;
    end
  end

`ifdef ONEWIRE_CRC8_EN
  logic [7:0] crc;
  logic       crc_fb;

  assign crc_fb = crc[0] ^ bus_s2;
  assign crc_ok = (crc == 8'h00);

  // Reflected Dallas CRC8, one bit per read sample; a bus reset starts a new frame.
  always_ff @(posedge clk) begin
    if (!reset)
      crc <= 8'h00;
    else if ((state == IDLE) && cmd_valid && (cmd_op == OP_RESET))
      crc <= 8'h00;
    else if (rd_sample)
      crc <= {1'b0, crc[7:1]} ^ (crc_fb ? 8'h8C : 8'h00);
  end
`endif

endmodule

// File: tb/tb_onewire_master_ctrl.sv
// Directed bench for onewire_master_ctrl with a simple behavioural 1-wire slave.
module tb_onewire_master_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd_op = 2'b00;
  logic [7:0] cmd_data = 8'h00;
  logic       cmd_ready;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_presence;
  logic       rsp_short;
`ifdef ONEWIRE_CRC8_EN
  logic       crc_ok;
`endif
  wire        onewire_bus;
  wire        bus_hi;

  logic       slave_low = 1'b0;
  logic       stuck_en = 1'b0;
  logic       pres_en = 1'b0;
  logic       rd_en = 1'b0;
  logic [7:0] rd_pattern = 8'h00;

  int n_cmp = 0;
  int n_bad = 0;

  pullup (onewire_bus);
  assign onewire_bus = (slave_low || stuck_en) ? 1'b0 : 1'bz;
  assign bus_hi = (onewire_bus !== 1'b0);

  always #5 clk = ~clk;

  onewire_master_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_data     (cmd_data),
    .rsp_valid    (rsp_valid),
    .rsp_data     (rsp_data),
    .rsp_presence (rsp_presence),
    .rsp_short    (rsp_short),
`ifdef ONEWIRE_CRC8_EN
    .crc_ok       (crc_ok),
`endif
    .onewire_bus  (onewire_bus)
  );

  // Low-pulse monitor plus slave model (presence pulse, read-slot pull-downs).
  int   cyc = 0;
  int   run = 0;
  logic prev = 1'b1;
  int   pres_dly = 0;
  int   hold = 0;
  int   rd_idx = 0;
  int   pulse_len[$];
  int   pulse_start[$];

  always @(negedge clk) begin
    cyc  <= cyc + 1;
    prev <= bus_hi;
    if (!bus_hi) run <= run + 1;
    else begin
      if (run != 0) begin
        pulse_len.push_back(run);
        pulse_start.push_back(cyc - run);
      end
      run <= 0;
    end
    if (bus_hi && !prev && (run >= 400) && pres_en) pres_dly <= 15;
    else if (pres_dly > 0) pres_dly <= pres_dly - 1;
    if (!rd_en) rd_idx <= 0;
    if (pres_dly == 1) begin
      slave_low <= 1'b1;
      hold      <= 120;
    end else if (!bus_hi && prev && rd_en) begin
      if (!rd_pattern[rd_idx[2:0]]) begin
        slave_low <= 1'b1;
        hold      <= 40;
      end
      rd_idx <= rd_idx + 1;
    end else if (hold > 1) begin
      hold <= hold - 1;
    end else if (hold == 1) begin
      hold      <= 0;
      slave_low <= 1'b0;
    end
  end

  task automatic issue(input logic [1:0] op, input logic [7:0] data);
    @(negedge clk);
    cmd_op    = op;
    cmd_data  = data;
    cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int budget, output int lat, output bit got);
    lat = 0;
    got = 1'b0;
    for (int k = 1; k <= budget && !got; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (rsp_valid === 1'b1) begin
        got = 1'b1;
        lat = k;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got %b want 1", cmd_ready); end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", rsp_valid); end
    n_cmp++; if (rsp_data !== 8'h00) begin n_bad++; $display("FAIL reset_data got %h want 00", rsp_data); end
    n_cmp++; if (rsp_presence !== 1'b0) begin n_bad++; $display("FAIL reset_presence got %b want 0", rsp_presence); end
    n_cmp++; if (rsp_short !== 1'b0) begin n_bad++; $display("FAIL reset_short got %b want 0", rsp_short); end
    n_cmp++; if (bus_hi !== 1'b1) begin n_bad++; $display("FAIL reset_bus got %b want released", bus_hi); end
`ifdef ONEWIRE_CRC8_EN
    n_cmp++; if (crc_ok !== 1'b1) begin n_bad++; $display("FAIL reset_crc_ok got %b want 1", crc_ok); end
`endif
  endtask

  task automatic test_bus_reset(input string name, input logic pres, input logic stuck,
                                input logic exp_pres, input logic exp_short);
    int lat;
    bit got;
    pres_en  = pres;
    stuck_en = stuck;
    pulse_len.delete();
    pulse_start.delete();
    issue(2'b00, 8'h00);
    wait_rsp(1100, lat, got);
    n_cmp++; if (!got) begin n_bad++; $display("FAIL %s_timeout got no rsp_valid want one", name); end
    n_cmp++; if (lat !== 1000) begin n_bad++; $display("FAIL %s_latency got %0d want 1000", name, lat); end
    n_cmp++; if (rsp_presence !== exp_pres) begin n_bad++; $display("FAIL %s_presence got %b want %b", name, rsp_presence, exp_pres); end
    n_cmp++; if (rsp_short !== exp_short) begin n_bad++; $display("FAIL %s_short got %b want %b", name, rsp_short, exp_short); end
    n_cmp++; if (rsp_data !== 8'h00) begin n_bad++; $display("FAIL %s_data got %h want 00", name, rsp_data); end
    if (!stuck) begin
      n_cmp++;
      if (((pulse_len.size() > 0) ? pulse_len[0] : -1) !== 500) begin
        n_bad++; $display("FAIL %s_low_time got %0d want 500", name, (pulse_len.size() > 0) ? pulse_len[0] : -1);
      end
    end
    @(negedge clk);
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL %s_pulse_width got %b want 0", name, rsp_valid); end
    n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL %s_ready_after got %b want 1", name, cmd_ready); end
    stuck_en = 1'b0;
    pres_en  = 1'b0;
    repeat (200) @(negedge clk);
  endtask

  task automatic test_write_byte();
    int lat;
    bit got;
    int exp_len[8] = '{10, 90, 10, 90, 90, 10, 90, 10};
    pulse_len.delete();
    pulse_start.delete();
    issue(2'b01, 8'hA5);
    wait_rsp(900, lat, got);
    n_cmp++; if (!got) begin n_bad++; $display("FAIL wr_timeout got no rsp_valid want one"); end
    n_cmp++; if (lat !== 800) begin n_bad++; $display("FAIL wr_latency got %0d want 800", lat); end
    n_cmp++; if (rsp_data !== 8'h00) begin n_bad++; $display("FAIL wr_data got %h want 00", rsp_data); end
    n_cmp++; if (pulse_len.size() !== 8) begin n_bad++; $display("FAIL wr_pulse_count got %0d want 8", pulse_len.size()); end
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (((i < pulse_len.size()) ? pulse_len[i] : -1) !== exp_len[i]) begin
        n_bad++; $display("FAIL wr_len%0d got %0d want %0d", i, (i < pulse_len.size()) ? pulse_len[i] : -1, exp_len[i]);
      end
    end
    for (int i = 1; i < 8; i++) begin
      n_cmp++;
      if (((i < pulse_start.size()) ? pulse_start[i] - pulse_start[i-1] : -1) !== 100) begin
        n_bad++; $display("FAIL wr_spacing%0d got %0d want 100", i, (i < pulse_start.size()) ? pulse_start[i] - pulse_start[i-1] : -1);
      end
    end
    repeat (20) @(negedge clk);
  endtask

  task automatic test_busy_ignored();
    int lat;
    bit got;
    pulse_len.delete();
    issue(2'b01, 8'hFF);
    repeat (50) @(negedge clk);
    cmd_op    = 2'b00;
    cmd_valid = 1'b1;
    repeat (5) @(negedge clk);
    cmd_valid = 1'b0;
    wait_rsp(900, lat, got);
    n_cmp++; if (!got) begin n_bad++; $display("FAIL busy_timeout got no rsp_valid want one"); end
    n_cmp++; if (lat !== 745) begin n_bad++; $display("FAIL busy_latency got %0d want 745", lat); end
    repeat (30) @(negedge clk);
    n_cmp++; if (pulse_len.size() !== 8) begin n_bad++; $display("FAIL busy_pulse_count got %0d want 8", pulse_len.size()); end
    n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL busy_ready got %b want 1", cmd_ready); end
  endtask

  task automatic test_write_bit(input logic [7:0] data, input int exp_low);
    int lat;
    bit got;
    pulse_len.delete();
    issue(2'b11, data);
    wait_rsp(200, lat, got);
    n_cmp++; if (!got) begin n_bad++; $display("FAIL bit_timeout data %h got no rsp_valid want one", data); end
    n_cmp++; if (lat !== 100) begin n_bad++; $display("FAIL bit_latency data %h got %0d want 100", data, lat); end
    repeat (5) @(negedge clk);
    n_cmp++; if (pulse_len.size() !== 1) begin n_bad++; $display("FAIL bit_count data %h got %0d want 1", data, pulse_len.size()); end
    n_cmp++;
    if (((pulse_len.size() > 0) ? pulse_len[0] : -1) !== exp_low) begin
      n_bad++; $display("FAIL bit_low data %h got %0d want %0d", data, (pulse_len.size() > 0) ? pulse_len[0] : -1, exp_low);
    end
  endtask

  task automatic test_read_byte(input logic [7:0] pattern, input logic slave_on);
    int lat;
    bit got;
    rd_pattern = pattern;
    rd_en      = slave_on;
    issue(2'b10, 8'h00);
    wait_rsp(900, lat, got);
    n_cmp++; if (!got) begin n_bad++; $display("FAIL rd_timeout pattern %h got no rsp_valid want one", pattern); end
    n_cmp++; if (lat !== 800) begin n_bad++; $display("FAIL rd_latency pattern %h got %0d want 800", pattern, lat); end
    n_cmp++; if (rsp_data !== pattern) begin n_bad++; $display("FAIL rd_data got %h want %h", rsp_data, pattern); end
    rd_en = 1'b0;
    repeat (60) @(negedge clk);
  endtask

  task automatic test_reset_mid_op();
    bit seen;
    pres_en = 1'b1;
    issue(2'b00, 8'h00);
    repeat (299) @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_cmp++; if (bus_hi !== 1'b1) begin n_bad++; $display("FAIL midrst_bus got %b want released", bus_hi); end
    n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL midrst_ready got %b want 1", cmd_ready); end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_valid got %b want 0", rsp_valid); end
    reset = 1'b1;
    seen = 1'b0;
    repeat (1100) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) seen = 1'b1;
    end
    n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL midrst_spurious_rsp got %b want 0", seen); end
    pres_en = 1'b0;
    test_bus_reset("after_midrst", 1'b1, 1'b0, 1'b1, 1'b0);
  endtask

`ifdef ONEWIRE_CRC8_EN
  task automatic test_crc();
    test_bus_reset("crc_frame", 1'b1, 1'b0, 1'b1, 1'b0);
    n_cmp++; if (crc_ok !== 1'b1) begin n_bad++; $display("FAIL crc_cleared got %b want 1", crc_ok); end
    test_read_byte(8'h01, 1'b1);
    n_cmp++; if (crc_ok !== 1'b0) begin n_bad++; $display("FAIL crc_byte1 got %b want 0", crc_ok); end
    test_read_byte(8'h5E, 1'b1);
    n_cmp++; if (crc_ok !== 1'b1) begin n_bad++; $display("FAIL crc_byte2 got %b want 1", crc_ok); end
  endtask
`endif

  initial begin
    test_reset();
    test_bus_reset("presence", 1'b1, 1'b0, 1'b1, 1'b0);
    test_bus_reset("no_slave", 1'b0, 1'b0, 1'b0, 1'b0);
    test_bus_reset("shorted", 1'b0, 1'b1, 1'b1, 1'b1);
    test_write_byte();
    test_busy_ignored();
    test_write_bit(8'hFE, 90);
    test_write_bit(8'h01, 10);
    test_read_byte(8'h02, 1'b1);
    test_read_byte(8'hFF, 1'b0);
    test_read_byte(8'hC3, 1'b1);
    test_reset_mid_op();
`ifdef ONEWIRE_CRC8_EN
    test_crc();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
